// File: rtl/ysyx_25020047_dmem_resp.sv
// rtl/ysyx_25020047_dmem_resp.sv - word-addressed data memory with fixed-latency valid/ready response
module ysyx_25020047_dmem_resp #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          AW      = 8,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int          DEPTH  = 1 << AW;
  localparam logic [32:0] LO     = {1'b0, BASE};
  localparam logic [32:0] HI     = {1'b0, BASE} + (33'd4 << AW);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          go_resp;
  logic          cur_wen;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wmask;
  logic          in_range;
  logic [AW-1:0] idx;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept  = (state_q == IDLE) && req_valid;
  assign go_resp = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd1));

  // With single-cycle latency the access happens on the accept edge, so use the live request.
  assign cur_wen   = (state_q == IDLE) ? req_wen   : wen_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_wmask = (state_q == IDLE) ? req_wmask : wmask_q;

  assign in_range = ({1'b0, cur_addr} >= LO) && ({1'b0, cur_addr} < HI);
  assign idx      = cur_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_wmask[b]) mem_q[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (go_resp) begin
        err_q   <= !in_range;
        rdata_q <= (in_range && !cur_wen) ? mem_q[idx] : 32'd0;
      end
    end
  end

endmodule

// File: doc/ysyx_25020047_dmem_resp.md
YSYX_25020047_DMEM_RESP -- requirements
Module: ysyx_25020047_dmem_resp

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter AW, default 8, meaning log2 of depth in 32-bit words (256 words).
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to rsp_valid; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-008 SHALL have port req_wen, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: write data, already lane-aligned.
REQ-011 SHALL have port req_wmask, input, 4 bits: byte enables, bit i gates lane i.
REQ-012 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-013 SHALL have port rsp_ready, input, 1 bit: the initiator takes the response.
REQ-014 SHALL have port rsp_rdata, output, 32 bits: full read word; 0 for writes and errors.
REQ-015 SHALL have port rsp_err, output, 1 bit: the address was out of range.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP, with req_ready = (state == IDLE) and rsp_valid = (state == RESP).
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, and latch wen, addr, wdata and wmask at that edge.
REQ-018 IDLE SHALL go to RESP on accept when LATENCY == 1; otherwise it SHALL go to WAIT and load the counter with LATENCY-1.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 SHALL index words by addr[AW+1:2], ignoring addr[1:0]; word alignment is the initiator's duty.
REQ-021 SHALL treat an address as in range when it is at least BASE and below BASE + 4*2^AW (unsigned 33-bit compare, no wrap); any other address is out of range.
REQ-022 On the edge entering RESP, an in-range write SHALL update only the lanes enabled by wmask; wmask == 0 is a legal no-op.
REQ-023 On the edge entering RESP, an in-range read SHALL register mem[index] into rsp_rdata; the read SHALL NOT modify memory.
REQ-024 An out-of-range request SHALL set rsp_err = 1 and rsp_rdata = 0, and SHALL perform no write.
REQ-025 rsp_rdata and rsp_err SHALL remain stable while rsp_valid = 1 and rsp_ready = 0.
REQ-026 RESP SHALL go to IDLE on the edge where rsp_ready = 1; a new request is therefore accepted no earlier than the following cycle.
REQ-027 req_valid SHALL be ignored outside IDLE, and input changes during WAIT SHALL NOT affect the latched request.
REQ-028 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-029 rst = 1 SHALL immediately force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and all latched request fields to 0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset during WAIT SHALL discard the pending request; no write commits and no response is produced.
REQ-032 Reset during RESP SHALL drop the response; a write already committed stays committed.
REQ-033 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Write then read, LATENCY = 2: write addr 8000_0010, wdata DEADBEEF, wmask F, rsp_ready = 1. Required: rsp_valid 2 cycles after accept, err 0. Then read addr 8000_0010: rsp_rdata = DEADBEEF.
REQ-035 Byte and half masks: over word 11223344, write wdata 0000AA00 with wmask 2. Read returns 1122AA44. Then write wdata BBBB0000 with wmask C. Read returns BBBBAA44.
REQ-036 Backpressure: read with rsp_ready held 0 for 5 cycles. Required: rsp_valid and rsp_rdata stable, req_ready 0 throughout, and a req_valid pulse in that window is not accepted.
REQ-037 Out of range: write addr 7FFF_FFFC, then read addr 8000_0400 (AW = 8). Required: both return rsp_err 1 and rsp_rdata 0, and memory word 0 and word 255 are unchanged.
REQ-038 Reset mid-operation: write 12345678 to 8000_0000, assert rst during WAIT, then read 8000_0000. Required: rsp_valid stays 0 during reset, and the read returns the prior contents, not 12345678.
REQ-039 LATENCY = 1 back-to-back: two reads with rsp_ready tied 1. Required: responses at accept+1, and the second accept occurs 2 cycles after the first.
